// File: rtl/fft_out_sequencer.sv
// Sequencer for the FFT output parallel-to-serial register: load, per-sample shift
// strobes, valid/ready presentation, frame completion and overrun reporting.
// Define FFT_OUTSEQ_PACE_EN to insert PACE_GAP idle cycles between accepted samples.
module fft_out_sequencer #(
    parameter int  NUM_SAMPLES = 32,
    parameter int  PACE_GAP    = 2,
    localparam int IDX_W       = $clog2(NUM_SAMPLES)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             fft_done,
    input  logic             abort,
    input  logic             sample_ready,
    output logic             load_enable,
    output logic             out_strobe,
    output logic             sample_valid,
    output logic [IDX_W-1:0] sample_index,
    output logic             frame_last,
    output logic             frame_done,
    output logic             busy,
    output logic             overrun
);

    if (NUM_SAMPLES < 2 || PACE_GAP < 1) begin : g_cfg_check
        $error("fft_out_sequencer: NUM_SAMPLES must be >= 2 and PACE_GAP >= 1");
    end

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);

`ifdef FFT_OUTSEQ_PACE_EN
    localparam int             GAP_W    = (PACE_GAP > 1) ? $clog2(PACE_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(PACE_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STROBE,
        S_PRESENT,
        S_GAP
    } state_t;

    logic [GAP_W-1:0] gap_cnt;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STROBE,
        S_PRESENT
    } state_t;
`endif

    state_t state;
    logic   load_q;
    logic   accept;
    logic   at_last;

    assign at_last      = (sample_index == LAST_IDX);
    assign sample_valid = (state == S_PRESENT);
    assign frame_last   = sample_valid & at_last;
    assign busy         = (state != S_IDLE);
    assign accept       = sample_valid & sample_ready;

    // An abort cycle must never move data, so both register controls are masked by it.
    assign load_enable  = load_q & ~abort;
`ifdef FFT_OUTSEQ_PACE_EN
    assign out_strobe   = ~abort & (state == S_STROBE);
`else
    assign out_strobe   = ~abort & ((state == S_STROBE) | (accept & ~at_last));
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= S_IDLE;
            sample_index <= '0;
            load_q       <= 1'b0;
            frame_done   <= 1'b0;
            overrun      <= 1'b0;
`ifdef FFT_OUTSEQ_PACE_EN
            gap_cnt      <= '0;
`endif
        end else begin
            load_q     <= 1'b0;
            frame_done <= 1'b0;
            // A new frame arriving mid-frame is dropped; abort suppresses the report.
            overrun    <= fft_done & (state != S_IDLE) & ~abort;

            if (abort) begin
                state        <= S_IDLE;
                sample_index <= '0;
`ifdef FFT_OUTSEQ_PACE_EN
                gap_cnt      <= '0;
`endif
            end else begin
                case (state)
                    S_IDLE: begin
                        if (fft_done) begin
                            state  <= S_LOAD;
                            load_q <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        state <= S_STROBE;
                    end
                    S_STROBE: begin
                        state <= S_PRESENT;
                    end
                    S_PRESENT: begin
                        if (sample_ready) begin
                            if (at_last) begin
                                state        <= S_IDLE;
                                sample_index <= '0;
                                frame_done   <= 1'b1;
                            end else begin
                                sample_index <= sample_index + 1'b1;
`ifdef FFT_OUTSEQ_PACE_EN
                                state        <= S_GAP;
                                gap_cnt      <= '0;
`endif
                            end
                        end
                    end
`ifdef FFT_OUTSEQ_PACE_EN
                    S_GAP: begin
                        if (gap_cnt == GAP_LAST) begin
                            state   <= S_STROBE;
                            gap_cnt <= '0;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
`endif
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
